// File: rtl/datapath_pkg.sv
// Shared definitions for the SCSI byte-lane packer: FSM encoding, direction codes and lane slicing.
package datapath_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PACK   = 3'd1,
    S_PUSH   = 3'd2,
    S_LOAD   = 3'd3,
    S_UNPACK = 3'd4
  } state_e;

  localparam logic DIR_S2F = 1'b0;
  localparam logic DIR_F2S = 1'b1;

  // Widest word / beat the slicing helper handles; callers zero-extend and truncate.
  localparam int unsigned MaxWordW = 64;
  localparam int unsigned MaxScsiW = 16;

  // Returns the lane'th scsi_w-wide slice of a word_w-wide word, lane 0 at the MSBs.
  function automatic logic [MaxScsiW-1:0] lane_sel(input logic [MaxWordW-1:0] word,
                                                   input int unsigned        word_w,
                                                   input int unsigned        scsi_w,
                                                   input int unsigned        lane);
    return MaxScsiW'(word >> (word_w - (lane + 1) * scsi_w));
  endfunction

endpackage

// File: rtl/datapath_lane_ctr.sv
// Lane counter for the packer: loadable, wraps LANES-1 -> 0, flags the last lane.
module datapath_lane_ctr #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CntW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            last_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntW'(LANES - 1));
  assign cnt_o  = cnt_q;

  // Load has priority over increment; increment wraps after the last lane.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/datapath_scsi_packer.sv
// SCSI <-> FIFO pack/unpack datapath with valid/ready on both sides.
// Optional odd-parity per byte on the SCSI port when SCSI_PARITY_EN is defined.
module datapath_scsi_packer
  import datapath_pkg::*;
#(
  parameter int unsigned SCSI_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic                CLK,
  input  logic                _RST,
  input  logic                DIR,
  input  logic                START,
  input  logic [1:0]          START_BO,
  input  logic                FLUSH,
  input  logic [SCSI_W-1:0]   SCSI_DIN,
  input  logic                SCSI_DIN_VLD,
  output logic                SCSI_DIN_RDY,
  output logic [SCSI_W-1:0]   SCSI_DOUT,
  output logic                SCSI_DOUT_VLD,
  input  logic                SCSI_DOUT_RDY,
  output logic [WORD_W-1:0]   FIFO_ID,
  output logic [WORD_W/8-1:0] FIFO_BE,
  output logic                FIFO_ID_VLD,
  input  logic                FIFO_ID_RDY,
  input  logic [WORD_W-1:0]   FIFO_OD,
  input  logic                FIFO_OD_VLD,
  output logic                FIFO_OD_RDY,
`ifdef SCSI_PARITY_EN
  input  logic [SCSI_W/8-1:0] SCSI_DIN_P,
  output logic [SCSI_W/8-1:0] SCSI_DOUT_P,
`endif
  output logic                BUSY,
  output logic                PERR
);

  localparam int unsigned LANES  = WORD_W / SCSI_W;
  localparam int unsigned CntW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BeW    = WORD_W / 8;
  localparam int unsigned BeLane = SCSI_W / 8;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   fifo_id_q, fifo_id_d;
  logic [BeW-1:0]      be_q, be_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [SCSI_W-1:0]   dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;
  logic                flush_push_q, flush_push_d;
  logic                perr_q, perr_d;
  logic                din_rdy_q, din_rdy_d;
  logic                od_rdy_q, od_rdy_d;
  logic                id_vld_q, id_vld_d;
  logic                busy_q, busy_d;

  logic [CntW-1:0]     lane_q, lane_nxt, start_lane, ctr_load_val;
  logic                lane_last, ctr_load, ctr_inc;
  logic                din_acc, dout_acc, od_acc, par_bad;
  logic [31:0]         pack_sh, be_sh;
  logic [WORD_W-1:0]   lane_mask, lane_data;
  logic [BeW-1:0]      lane_be;
  logic [SCSI_W-1:0]   sel_load, sel_next;

  datapath_lane_ctr #(
    .LANES (LANES),
    .CntW  (CntW)
  ) u_lane_ctr (
    .clk_i      (CLK),
    .rst_ni     (_RST),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .inc_i      (ctr_inc),
    .cnt_o      (lane_q),
    .last_o     (lane_last)
  );

  // With 16-bit beats the byte offset's LSB is dropped.
  assign start_lane = CntW'(START_BO >> (SCSI_W / 16));
  assign lane_nxt   = lane_q + CntW'(1);

  assign din_acc  = SCSI_DIN_VLD & din_rdy_q;
  assign dout_acc = SCSI_DOUT_RDY & dout_vld_q;
  assign od_acc   = FIFO_OD_VLD & od_rdy_q;

  // Big-endian lane placement for packing.
  assign pack_sh   = (LANES - 1 - 32'(lane_q)) * SCSI_W;
  assign be_sh     = (LANES - 1 - 32'(lane_q)) * BeLane;
  assign lane_mask = WORD_W'({SCSI_W{1'b1}}) << pack_sh;
  assign lane_data = WORD_W'(SCSI_DIN) << pack_sh;
  assign lane_be   = BeW'({BeLane{1'b1}}) << be_sh;

  assign sel_load = SCSI_W'(lane_sel(MaxWordW'(FIFO_OD), WORD_W, SCSI_W, 32'(lane_q)));
  assign sel_next = SCSI_W'(lane_sel(MaxWordW'(buf_q), WORD_W, SCSI_W, 32'(lane_nxt)));

`ifdef SCSI_PARITY_EN
  // Odd parity: each byte plus its parity bit must hold an odd number of ones.
  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < BeLane; b++) begin
      if (!(^{SCSI_DIN[b*8 +: 8], SCSI_DIN_P[b]})) par_bad = 1'b1;
    end
  end

  // Parity for the registered write beat.
  always_comb begin
    SCSI_DOUT_P = '0;
    for (int b = 0; b < BeLane; b++) begin
      SCSI_DOUT_P[b] = ~(^dout_q[b*8 +: 8]);
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // FSM next state, datapath updates and next values of the registered handshake outputs.
  always_comb begin
    state_d      = state_q;
    fifo_id_d    = fifo_id_q;
    be_d         = be_q;
    buf_d        = buf_q;
    dout_d       = dout_q;
    dout_vld_d   = dout_vld_q;
    flush_push_d = flush_push_q;
    perr_d       = perr_q;
    ctr_load     = 1'b0;
    ctr_load_val = start_lane;
    ctr_inc      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          ctr_load   = 1'b1;
          perr_d     = 1'b0;
          fifo_id_d  = '0;
          be_d       = '0;
          dout_vld_d = 1'b0;
          state_d    = (DIR == DIR_F2S) ? S_LOAD : S_PACK;
        end
      end
      S_PACK: begin
        if (din_acc) begin
          fifo_id_d = (fifo_id_q & ~lane_mask) | lane_data;
          be_d      = be_q | lane_be;
          ctr_inc   = 1'b1;
          if (par_bad) perr_d = 1'b1;
        end
        if (FLUSH) begin
          // A beat accepted alongside FLUSH still counts toward the partial word.
          if (din_acc || (be_q != '0)) begin
            flush_push_d = 1'b1;
            state_d      = S_PUSH;
          end else begin
            state_d = S_IDLE;
          end
        end else if (din_acc && lane_last) begin
          flush_push_d = 1'b0;
          state_d      = S_PUSH;
        end
      end
      S_PUSH: begin
        if (FIFO_ID_RDY) begin
          fifo_id_d    = '0;
          be_d         = '0;
          ctr_load     = 1'b1;
          ctr_load_val = '0;
          state_d      = flush_push_q ? S_IDLE : S_PACK;
        end
      end
      S_LOAD: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else if (od_acc) begin
          buf_d      = FIFO_OD;
          dout_d     = sel_load;
          dout_vld_d = 1'b1;
          state_d    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (dout_acc) begin
          ctr_inc = 1'b1;
          if (lane_last) begin
            dout_vld_d = 1'b0;
            state_d    = S_LOAD;
          end else begin
            dout_d = sel_next;
          end
        end
        if (FLUSH) begin
          dout_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    din_rdy_d = (state_d == S_PACK);
    od_rdy_d  = (state_d == S_LOAD);
    id_vld_d  = (state_d == S_PUSH);
    busy_d    = (state_d != S_IDLE);
  end

  // All state and registered outputs.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q      <= S_IDLE;
      fifo_id_q    <= '0;
      be_q         <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      flush_push_q <= 1'b0;
      perr_q       <= 1'b0;
      din_rdy_q    <= 1'b0;
      od_rdy_q     <= 1'b0;
      id_vld_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_id_q    <= fifo_id_d;
      be_q         <= be_d;
      buf_q        <= buf_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      flush_push_q <= flush_push_d;
      perr_q       <= perr_d;
      din_rdy_q    <= din_rdy_d;
      od_rdy_q     <= od_rdy_d;
      id_vld_q     <= id_vld_d;
      busy_q       <= busy_d;
    end
  end

  assign SCSI_DIN_RDY  = din_rdy_q;
  assign SCSI_DOUT     = dout_q;
  assign SCSI_DOUT_VLD = dout_vld_q;
  assign FIFO_ID       = fifo_id_q;
  assign FIFO_BE       = be_q;
  assign FIFO_ID_VLD   = id_vld_q;
  assign FIFO_OD_RDY   = od_rdy_q;
  assign BUSY          = busy_q;
  assign PERR          = perr_q;

endmodule

// File: tb/tb_datapath_scsi_packer.sv
// Directed bench for datapath_scsi_packer: an 8-bit-beat and a 16-bit-beat instance share one clock.
module tb_datapath_scsi_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dir, start8, start16, flush, din_vld, dout_rdy, id_rdy, od_vld;
  logic [1:0]  bo;
  logic [7:0]  din8;
  logic [15:0] din16;
  logic [31:0] od;
  logic [0:0]  p8;
  logic [1:0]  p16;

  logic        din_rdy8, dout_vld8, id_vld8, od_rdy8, busy8, perr8;
  logic [7:0]  dout8;
  logic [31:0] id8;
  logic [3:0]  be8;
  logic [0:0]  dp8;
  logic        din_rdy16, dout_vld16, id_vld16, od_rdy16, busy16, perr16;
  logic [15:0] dout16;
  logic [31:0] id16;
  logic [3:0]  be16;
  logic [1:0]  dp16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  datapath_scsi_packer #(.SCSI_W(8), .WORD_W(32)) u_dut8 (
    .CLK           (clk),
    ._RST          (rst_n),
    .DIR           (dir),
    .START         (start8),
    .START_BO      (bo),
    .FLUSH         (flush),
    .SCSI_DIN      (din8),
    .SCSI_DIN_VLD  (din_vld),
    .SCSI_DIN_RDY  (din_rdy8),
    .SCSI_DOUT     (dout8),
    .SCSI_DOUT_VLD (dout_vld8),
    .SCSI_DOUT_RDY (dout_rdy),
    .FIFO_ID       (id8),
    .FIFO_BE       (be8),
    .FIFO_ID_VLD   (id_vld8),
    .FIFO_ID_RDY   (id_rdy),
    .FIFO_OD       (od),
    .FIFO_OD_VLD   (od_vld),
    .FIFO_OD_RDY   (od_rdy8),
`ifdef SCSI_PARITY_EN
    .SCSI_DIN_P    (p8),
    .SCSI_DOUT_P   (dp8),
`endif
    .BUSY          (busy8),
    .PERR          (perr8)
  );

  datapath_scsi_packer #(.SCSI_W(16), .WORD_W(32)) u_dut16 (
    .CLK           (clk),
    ._RST          (rst_n),
    .DIR           (dir),
    .START         (start16),
    .START_BO      (bo),
    .FLUSH         (flush),
    .SCSI_DIN      (din16),
    .SCSI_DIN_VLD  (din_vld),
    .SCSI_DIN_RDY  (din_rdy16),
    .SCSI_DOUT     (dout16),
    .SCSI_DOUT_VLD (dout_vld16),
    .SCSI_DOUT_RDY (dout_rdy),
    .FIFO_ID       (id16),
    .FIFO_BE       (be16),
    .FIFO_ID_VLD   (id_vld16),
    .FIFO_ID_RDY   (id_rdy),
    .FIFO_OD       (od),
    .FIFO_OD_VLD   (od_vld),
    .FIFO_OD_RDY   (od_rdy16),
`ifdef SCSI_PARITY_EN
    .SCSI_DIN_P    (p16),
    .SCSI_DOUT_P   (dp16),
`endif
    .BUSY          (busy16),
    .PERR          (perr16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic d, input logic [1:0] b);
    dir    = d;
    bo     = b;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] b, input logic bad);
    int tmo = 0;
    din8    = b;
    din_vld = 1'b1;
    p8[0]   = bad ? (^b) : ~(^b);
    while (!din_rdy8 && tmo < 20) begin
      tick();
      tmo++;
    end
    check("din_rdy_wait", 64'(din_rdy8), 64'd1);
    tick();
    din_vld = 1'b0;
  endtask

  task automatic pop();
    id_rdy = 1'b1;
    tick();
    id_rdy = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [4];
    int         od_cnt;
    int         tmo;
    logic       saw_vld;

    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rst_n = 1'b0; dir = 1'b0; start8 = 1'b0; start16 = 1'b0; flush = 1'b0; bo = 2'd0;
    din8 = '0; din16 = '0; din_vld = 1'b0; dout_rdy = 1'b0; id_rdy = 1'b0;
    od = '0; od_vld = 1'b0; p8 = '0; p16 = '0;
    repeat (3) tick();

    // Reset state
    check("rst_id", 64'(id8), 64'd0);
    check("rst_be", 64'(be8), 64'd0);
    check("rst_flags8", 64'({din_rdy8, dout_vld8, id_vld8, od_rdy8, busy8, perr8}), 64'd0);
    check("rst_dout", 64'(dout8), 64'd0);
    check("rst_flags16", 64'({din_rdy16, dout_vld16, id_vld16, od_rdy16, busy16, perr16}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Aligned pack of four bytes
    go8(1'b0, 2'd0);
    check("t1_busy", 64'(busy8), 64'd1);
    check("t1_din_rdy", 64'(din_rdy8), 64'd1);
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b0);
    send8(8'h33, 1'b0);
    check("t1_no_vld_early", 64'(id_vld8), 64'd0);
    send8(8'h44, 1'b0);
    check("t1_vld", 64'(id_vld8), 64'd1);
    check("t1_word", 64'(id8), 64'h11223344);
    check("t1_be", 64'(be8), 64'hF);
    check("t1_din_rdy_push", 64'(din_rdy8), 64'd0);
    pop();
    check("t1_vld_drop", 64'(id_vld8), 64'd0);
    check("t1_back_pack", 64'(din_rdy8), 64'd1);
    do_flush();
    check("t1_idle", 64'(busy8), 64'd0);

    // Misaligned start, FIFO stall in PUSH, then a full word
    go8(1'b0, 2'd2);
    send8(8'hAA, 1'b0);
    send8(8'hBB, 1'b0);
    check("t2_vld", 64'(id_vld8), 64'd1);
    check("t2_word", 64'(id8), 64'h0000AABB);
    check("t2_be", 64'(be8), 64'h3);
    din8    = 8'h01;
    din_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_din_rdy", 64'(din_rdy8), 64'd0);
      check("stall_word", 64'(id8), 64'h0000AABB);
      check("stall_vld", 64'(id_vld8), 64'd1);
    end
    pop();
    send8(8'h01, 1'b0);
    send8(8'h02, 1'b0);
    send8(8'h03, 1'b0);
    send8(8'h04, 1'b0);
    check("t2_word2", 64'(id8), 64'h01020304);
    check("t2_be2", 64'(be8), 64'hF);
    check("t2_vld2", 64'(id_vld8), 64'd1);
    pop();
    do_flush();
    check("t2_idle", 64'(busy8), 64'd0);

    // 16-bit beat, partial word flushed
    dir = 1'b0; bo = 2'd0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    check("t3_din_rdy", 64'(din_rdy16), 64'd1);
    din16 = 16'hBEEF; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    check("t3_no_vld", 64'(id_vld16), 64'd0);
    do_flush();
    check("t3_vld", 64'(id_vld16), 64'd1);
    check("t3_word", 64'(id16), 64'hBEEF0000);
    check("t3_be", 64'(be16), 64'hC);
    pop();
    check("t3_idle", 64'(busy16), 64'd0);
    check("t3_vld_drop", 64'(id_vld16), 64'd0);

    // Unpack with 3 cycles of backpressure on every beat
    od = 32'hDEADBEEF; od_vld = 1'b1; od_cnt = 0;
    go8(1'b1, 2'd0);
    if (od_rdy8) od_cnt++;
    for (int i = 0; i < 4; i++) begin
      tmo = 0;
      while (!dout_vld8 && tmo < 10) begin
        tick();
        if (od_rdy8) od_cnt++;
        tmo++;
      end
      check("t4_dout_vld", 64'(dout_vld8), 64'd1);
      od_vld = 1'b0;
      check("t4_dout", 64'(dout8), 64'(exp_b[i]));
`ifdef SCSI_PARITY_EN
      if (i == 0) check("t4_dout_p", 64'(dp8), 64'd1);
`endif
      for (int k = 0; k < 3; k++) begin
        tick();
        if (od_rdy8) od_cnt++;
        check("t4_hold", 64'(dout8), 64'(exp_b[i]));
        check("t4_hold_vld", 64'(dout_vld8), 64'd1);
      end
      dout_rdy = 1'b1;
      tick();
      dout_rdy = 1'b0;
    end
    check("t4_dout_vld_end", 64'(dout_vld8), 64'd0);
    check("t4_od_rdy_once", 64'(od_cnt), 64'd1);
    do_flush();
    check("t4_idle", 64'(busy8), 64'd0);

    // Reset in the middle of a pack
    go8(1'b0, 2'd0);
    send8(8'h55, 1'b0);
    send8(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_id", 64'(id8), 64'd0);
    check("t5_rst_be", 64'(be8), 64'd0);
    check("t5_rst_flags", 64'({din_rdy8, id_vld8, busy8}), 64'd0);
    tick();
    rst_n   = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (id_vld8) saw_vld = 1'b1;
    end
    check("t5_no_word", 64'(saw_vld), 64'd0);
    check("t5_idle", 64'(busy8), 64'd0);

`ifdef SCSI_PARITY_EN
    // Bad-parity read beat sets sticky PERR until the next START
    go8(1'b0, 2'd0);
    send8(8'h01, 1'b0);
    check("t6_perr_good", 64'(perr8), 64'd0);
    send8(8'h03, 1'b1);
    check("t6_perr_set", 64'(perr8), 64'd1);
    do_flush();
    pop();
    check("t6_perr_sticky", 64'(perr8), 64'd1);
    go8(1'b0, 2'd0);
    check("t6_perr_clr", 64'(perr8), 64'd0);
    do_flush();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
